uart_transmit: RTL and testbench

UART 8N1 transmitter serialising one byte per request onto a single line. It sits directly upstream of the `recieve` block: its `txd` output drives that block's `rxd` input. Bit timing is a fixed clock divider. The idle line is high; data goes LSB first.

---
 rtl/uart_transmit.sv | 141 ++++++++++++++
 tb/tb_uart_transmit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmit.sv
// uart_transmit: 8N1 UART transmitter with a fixed clock divider, LSB first, idle-high line.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit(s).
module uart_transmit #(
  parameter int CLKS_PER_BIT = 10,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] word,
  input  logic       send,
  output logic       txd,
  output logic       transmit_ready,
  output logic       transmit_done
);

  localparam int          DIV_W     = $clog2(CLKS_PER_BIT);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [2:0]       r_idx, w_idx_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             r_txd, w_txd_nxt;
  logic             r_done, w_done_nxt;
  logic             w_bit_end;
`ifdef UART_TX_PARITY_EN
  logic             r_parity, w_parity_nxt;
`endif

  assign w_bit_end = (r_div == DIV_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_div    <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_txd    <= 1'b1;
      r_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_div    <= w_div_nxt;
      r_idx    <= w_idx_nxt;
      r_shift  <= w_shift_nxt;
      r_txd    <= w_txd_nxt;
      r_done   <= w_done_nxt;
`ifdef UART_TX_PARITY_EN
      r_parity <= w_parity_nxt;
`endif
    end
  end

  // txd is the registered next value so the line changes exactly on bit boundaries.
  always_comb begin
    w_state_nxt  = r_state;
    w_div_nxt    = w_bit_end ? '0 : r_div + DIV_W'(1);
    w_idx_nxt    = r_idx;
    w_shift_nxt  = r_shift;
    w_txd_nxt    = r_txd;
    w_done_nxt   = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_parity_nxt = r_parity;
`endif
    case (r_state)
      S_IDLE: begin
        w_txd_nxt = 1'b1;
        w_div_nxt = '0;
        w_idx_nxt = '0;
        if (send) begin
          w_shift_nxt  = word;
          w_txd_nxt    = 1'b0;
          w_state_nxt  = S_START;
`ifdef UART_TX_PARITY_EN
          w_parity_nxt = ^word;
`endif
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_txd_nxt   = r_shift[0];
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_idx == 3'd7) begin
            w_idx_nxt   = '0;
`ifdef UART_TX_PARITY_EN
            w_txd_nxt   = r_parity;
            w_state_nxt = S_PARITY;
`else
            w_txd_nxt   = 1'b1;
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_idx_nxt = r_idx + 3'd1;
            w_txd_nxt = r_shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_txd_nxt   = 1'b1;
          w_state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          if (r_idx == STOP_LAST) begin
            w_idx_nxt   = '0;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end
      end
      default: begin
        w_txd_nxt   = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign txd            = r_txd;
  assign transmit_ready = (r_state == S_IDLE);
  assign transmit_done  = r_done;

endmodule

// File: tb/tb_uart_transmit.sv
// tb_uart_transmit: table-driven frame checks plus a line-decoding monitor fed by an expected-byte queue.
// Works with or without UART_TX_PARITY_EN defined.
module tb_uart_transmit;

  localparam int C = 10;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB       = 10 + PAR;
  localparam int MON_LAST = (NB - 1) * C + C / 2 + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] word = 8'h00;
  logic       send = 1'b0;
  logic       txd, transmit_ready, transmit_done;
  logic [7:0] word2 = 8'h00;
  logic       send2 = 1'b0;
  logic       txd2, ready2, done2;

  int         n_checks = 0;
  int         n_fail = 0;
  int         mon_frames = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic [7:0] w;
    logic [0:9] seq;
    logic       par;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  uart_transmit #(.CLKS_PER_BIT(C), .STOP_BITS(1)) u_dut (
    .clk(clk), .rst(rst), .word(word), .send(send),
    .txd(txd), .transmit_ready(transmit_ready), .transmit_done(transmit_done)
  );

  uart_transmit #(.CLKS_PER_BIT(C), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .word(word2), .send(send2),
    .txd(txd2), .transmit_ready(ready2), .transmit_done(done2)
  );

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (transmit_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("wait_ready", transmit_ready, 1'b1);
  endtask

  // Sends one byte and checks every cycle of the frame against the expected line sequence.
  task automatic run_frame(input logic [7:0] w, input logic [0:9] seq, input logic par);
    logic busy_act;
    wait_ready();
    word = w;
    send = 1'b1;
    sb.push_back(w);
    @(negedge clk);
    send = 1'b0;
    busy_act = 1'b0;
    for (int b = 0; b < NB; b++) begin
      logic e, a;
      if (b < 9)                   e = seq[b];
      else if (PAR == 1 && b == 9) e = par;
      else                         e = 1'b1;
      a = e;
      for (int c = 0; c < C; c++) begin
        if (txd !== e) a = txd;
        if (transmit_ready !== 1'b0 || transmit_done !== 1'b0) busy_act = 1'b1;
        @(negedge clk);
      end
      check($sformatf("frame_%02h_bit%0d", w, b), a, e);
    end
    check($sformatf("frame_%02h_busy", w), busy_act, 1'b0);
    check($sformatf("frame_%02h_done", w), {txd, transmit_ready, transmit_done}, 3'b111);
    @(negedge clk);
    check($sformatf("frame_%02h_done_width", w), transmit_done, 1'b0);
  endtask

  // Line monitor: decodes each frame at bit centres and compares with the queued byte.
  logic [0:NB-1] mon_bits;
  bit            mon_abort;
  logic [7:0]    mon_byte, mon_exp;
  initial begin
    mon_bits = '0;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && txd === 1'b0) begin
        mon_abort = 1'b0;
        for (int k = 1; k <= MON_LAST; k++) begin
          if (k > 1) @(negedge clk);
          if (rst === 1'b1) begin
            mon_abort = 1'b1;
            break;
          end
          if ((k - 1) % C == C / 2) mon_bits[(k - 1) / C] = txd;
        end
        if (mon_abort) begin
          if (sb.size() > 0) void'(sb.pop_front());
        end else begin
          for (int i = 0; i < 8; i++) mon_byte[i] = mon_bits[i + 1];
          check("mon_sb_nonempty", (sb.size() > 0), 1'b1);
          if (sb.size() > 0) begin
            mon_exp = sb.pop_front();
            check("mon_start", mon_bits[0], 1'b0);
            check("mon_data", mon_byte, mon_exp);
`ifdef UART_TX_PARITY_EN
            check("mon_parity", mon_bits[9], ^mon_exp);
`endif
            check("mon_stop", mon_bits[NB-1], 1'b1);
          end
          mon_frames++;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] act;
    vecs[0] = '{8'hA5, 10'b0101001011, 1'b0};
    vecs[1] = '{8'h3C, 10'b0001111001, 1'b0};
    vecs[2] = '{8'hFF, 10'b0111111111, 1'b0};
    vecs[3] = '{8'h07, 10'b0111000001, 1'b1};
    vecs[4] = '{8'h0F, 10'b0111100001, 1'b0};

    // Reset held with send asserted
    send = 1'b1;
    word = 8'hA5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_outputs", {txd, transmit_ready, transmit_done}, 3'b110);
    end
    rst  = 1'b0;
    send = 1'b0;
    act  = 16'h6;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ({txd, transmit_ready, transmit_done} !== 3'b110) act = {13'd0, txd, transmit_ready, transmit_done};
    end
    check("post_rst_idle", act, 16'h6);

    for (int i = 0; i < 5; i++) run_frame(vecs[i].w, vecs[i].seq, vecs[i].par);

    // Back-to-back with send held, word change and extra send while busy
    wait_ready();
    word = 8'h00;
    send = 1'b1;
    sb.push_back(8'h00);
    @(negedge clk);
    repeat (49) @(negedge clk);
    word = 8'h81;
    sb.push_back(8'h81);
    repeat (NB * C - 50) @(negedge clk);
    check("b2b_last_stop", {txd, transmit_ready, transmit_done}, 3'b100);
    @(negedge clk);
    check("b2b_gap", {txd, transmit_ready, transmit_done}, 3'b111);
    @(negedge clk);
    check("b2b_second_start", {txd, transmit_ready, transmit_done}, 3'b000);
    send = 1'b0;
    repeat (49) @(negedge clk);
    word = 8'hEE;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    repeat (NB * C - 50) @(negedge clk);
    check("b2b_second_done", {txd, transmit_ready, transmit_done}, 3'b111);
    act = 16'h6;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if ({txd, transmit_ready, transmit_done} !== 3'b110) act = {13'd0, txd, transmit_ready, transmit_done};
    end
    check("b2b_no_third_frame", act, 16'h6);

    // Reset during data bit 3 of 8'h55
    wait_ready();
    word = 8'h55;
    send = 1'b1;
    sb.push_back(8'h55);
    @(negedge clk);
    send = 1'b0;
    repeat (44) @(negedge clk);
    check("pre_rst_bit3", txd, 1'b0);
    #1 rst = 1'b1;
    #1 check("async_rst_line", {txd, transmit_ready, transmit_done}, 3'b110);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    act = 16'h6;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if ({txd, transmit_ready, transmit_done} !== 3'b110) act = {13'd0, txd, transmit_ready, transmit_done};
    end
    check("rst_abort_no_done", act, 16'h6);
    run_frame(8'h0F, 10'b0111100001, 1'b0);

    // Two stop bits
    word2 = 8'h00;
    send2 = 1'b1;
    @(negedge clk);
    send2 = 1'b0;
    repeat ((9 + PAR) * C - 1) @(negedge clk);
    check("s2_last_low", {txd2, ready2}, 2'b00);
    act = 16'h2;
    for (int i = 0; i < 2 * C; i++) begin
      @(negedge clk);
      if ({txd2, ready2} !== 2'b10) act = {14'd0, txd2, ready2};
    end
    check("s2_stop_period", act, 16'h2);
    @(negedge clk);
    check("s2_done", {txd2, ready2, done2}, 3'b111);
    @(negedge clk);
    check("s2_done_width", done2, 1'b0);

    repeat (20) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    check("frame_count", mon_frames, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
